wb_classic_arbiter: RTL and testbench

//  Shares one Wishbone-classic device port between NUM_CTRL controllers.

---
 rtl/wb_classic_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_wb_classic_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_classic_arbiter.sv
// wb_classic_arbiter
//   Shares one Wishbone-classic device port between NUM_CTRL controllers.
//   Round-robin arbitration. A grant is held for the whole bus cycle, which
//   lasts while the owner keeps cyc high. An optional watchdog ends a stalled
//   cycle by returning err to the owner.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   ctrl_cyc/stb/we_i      per-controller request strobes  [NUM_CTRL]
//   ctrl_dat_i             per-controller write data, ctrl k at [k*DW +: DW]
//   ctrl_ack/err/rty_o     responses, routed to the owner only  [NUM_CTRL]
//   ctrl_dat_o             read data, broadcast (qualified by the owner's ack)
//   dev_cyc/stb/we/dat_o   shared device request
//   dev_ack/err/rty/dat_i  shared device response
//   grant_o                one-hot registered owner; 0 when idle
module wb_classic_arbiter #(
    parameter int NUM_CTRL  = 4,
    parameter int DAT_WIDTH = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_CTRL-1:0]           ctrl_cyc_i,
    input  logic [NUM_CTRL-1:0]           ctrl_stb_i,
    input  logic [NUM_CTRL-1:0]           ctrl_we_i,
    input  logic [NUM_CTRL*DAT_WIDTH-1:0] ctrl_dat_i,
    output logic [NUM_CTRL-1:0]           ctrl_ack_o,
    output logic [NUM_CTRL-1:0]           ctrl_err_o,
    output logic [NUM_CTRL-1:0]           ctrl_rty_o,
    output logic [DAT_WIDTH-1:0]          ctrl_dat_o,
    output logic                          dev_cyc_o,
    output logic                          dev_stb_o,
    output logic                          dev_we_o,
    output logic [DAT_WIDTH-1:0]          dev_dat_o,
    input  logic                          dev_ack_i,
    input  logic                          dev_err_i,
    input  logic                          dev_rty_i,
    input  logic [DAT_WIDTH-1:0]          dev_dat_i,
    output logic [NUM_CTRL-1:0]           grant_o
);

    localparam int PW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_ABORT = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_CTRL-1:0]   grant_q, grant_d;
    logic [PW-1:0]         own_q, own_d;
    logic [PW-1:0]         ptr_q, ptr_d;

    logic [NUM_CTRL-1:0][DAT_WIDTH-1:0] ctrl_dat_v;
    assign ctrl_dat_v = ctrl_dat_i;

    logic          owned, abort;
    logic          dev_rsp;
    logic          wd_fire;
    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] own_inc;
    int            scan_idx;

    assign owned   = (state_q == S_OWNED);
    assign abort   = (state_q == S_ABORT);
    assign dev_rsp = dev_ack_i | dev_err_i | dev_rty_i;
    assign own_inc = (own_q == PW'(NUM_CTRL - 1)) ? '0 : own_q + 1'b1;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester scanning ptr, ptr+1, ... mod N.
    // ------------------------------------------------------------------
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            scan_idx = (int'(ptr_q) + i) % NUM_CTRL;
            if (!pick_vld && ctrl_cyc_i[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(scan_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Owner mux to the device. Only the registered grant selects, so the
    // device never sees a request from a controller that is still waiting.
    // ------------------------------------------------------------------
    always_comb begin
        dev_cyc_o = 1'b0;
        dev_stb_o = 1'b0;
        dev_we_o  = 1'b0;
        dev_dat_o = '0;
        if (owned) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (grant_q[k]) begin
                    dev_cyc_o = ctrl_cyc_i[k];
                    dev_stb_o = ctrl_stb_i[k];
                    dev_we_o  = ctrl_we_i[k];
                    dev_dat_o = ctrl_dat_v[k];
                end
            end
        end
    end

    // Responses go to the owner only, gated by its own cyc. ack/err/rty are
    // routed independently so simultaneous device strobes are not merged.
    // An abort cycle forces err to the stalled owner.
    genvar g;
    generate
        for (g = 0; g < NUM_CTRL; g++) begin : g_rsp
            logic sel;
            assign sel           = owned & grant_q[g] & ctrl_cyc_i[g];
            assign ctrl_ack_o[g] = sel & dev_ack_i;
            assign ctrl_rty_o[g] = sel & dev_rty_i;
            assign ctrl_err_o[g] = (sel & dev_err_i) | (abort & grant_q[g]);
        end
    endgenerate

    assign ctrl_dat_o = owned ? dev_dat_i : '0;
    assign grant_o    = grant_q;

    // ------------------------------------------------------------------
    // Watchdog: counts consecutive unanswered strobed cycles while owned.
    // A response in the firing cycle suppresses the abort.
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] wd_cnt_q, wd_cnt_d;
            logic          stall;

            assign stall   = owned & dev_cyc_o & dev_stb_o & ~dev_rsp;
            assign wd_fire = stall & (wd_cnt_q == WD_LAST);

            always_comb begin
                wd_cnt_d = '0;
                if (stall && !wd_fire) wd_cnt_d = wd_cnt_q + 1'b1;
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) wd_cnt_q <= '0;
                else         wd_cnt_q <= wd_cnt_d;
            end
        end else begin : g_no_wd
            assign wd_fire = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_OWNED;
                    own_d   = pick_idx;
                    grant_d = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            S_OWNED: begin
                if (!ctrl_cyc_i[own_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = own_inc;
                end else if (wd_fire) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                // Stalled owner moves to the back of the rotation.
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = own_inc;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_wb_classic_arbiter.sv
// Directed bench for wb_classic_arbiter (NUM_CTRL=4, DAT_WIDTH=8, TIMEOUT=4).
module tb_wb_classic_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [N-1:0]  ctrl_cyc_i, ctrl_stb_i, ctrl_we_i;
    logic [N*DW-1:0] ctrl_dat_i;
    logic [N-1:0]  ctrl_ack_o, ctrl_err_o, ctrl_rty_o;
    logic [DW-1:0] ctrl_dat_o;
    logic          dev_cyc_o, dev_stb_o, dev_we_o;
    logic [DW-1:0] dev_dat_o;
    logic          dev_ack_i, dev_err_i, dev_rty_i;
    logic [DW-1:0] dev_dat_i;
    logic [N-1:0]  grant_o;

    int n_cmp = 0;
    int n_err = 0;

    wb_classic_arbiter #(.NUM_CTRL(N), .DAT_WIDTH(DW), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ctrl_cyc_i(ctrl_cyc_i), .ctrl_stb_i(ctrl_stb_i), .ctrl_we_i(ctrl_we_i),
        .ctrl_dat_i(ctrl_dat_i),
        .ctrl_ack_o(ctrl_ack_o), .ctrl_err_o(ctrl_err_o), .ctrl_rty_o(ctrl_rty_o),
        .ctrl_dat_o(ctrl_dat_o),
        .dev_cyc_o(dev_cyc_o), .dev_stb_o(dev_stb_o), .dev_we_o(dev_we_o),
        .dev_dat_o(dev_dat_o),
        .dev_ack_i(dev_ack_i), .dev_err_i(dev_err_i), .dev_rty_i(dev_rty_i),
        .dev_dat_i(dev_dat_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge; inputs change and checks happen here.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic req(input int k, input logic v);
        ctrl_cyc_i[k] = v;
        ctrl_stb_i[k] = v;
    endtask

    initial begin
        rst_ni = 1'b0;
        ctrl_cyc_i = '0; ctrl_stb_i = '0; ctrl_we_i = '0; ctrl_dat_i = '0;
        dev_ack_i = 1'b0; dev_err_i = 1'b0; dev_rty_i = 1'b0; dev_dat_i = '0;

        // ---------------- reset state ----------------
        tick();
        chk("rst_grant", grant_o, 0);
        chk("rst_dev_cyc", dev_cyc_o, 0);
        chk("rst_resp", {ctrl_ack_o, ctrl_err_o, ctrl_rty_o}, 0);
        rst_ni = 1'b1;
        tick();

        // ---------------- 1: single write by ctrl1 ----------------
        req(1, 1'b1); ctrl_we_i[1] = 1'b1; ctrl_dat_i[1*DW +: DW] = 8'hA5;
        #1;
        chk("t1_idle_dev_cyc", dev_cyc_o, 0);
        chk("t1_idle_grant", grant_o, 0);
        tick();
        chk("t1_grant", grant_o, 4'b0010);
        chk("t1_dev_cyc", dev_cyc_o, 1);
        chk("t1_dev_we", dev_we_o, 1);
        chk("t1_dev_dat", dev_dat_o, 8'hA5);
        chk("t1_no_ack_yet", ctrl_ack_o, 0);
        tick();
        dev_ack_i = 1'b1; dev_dat_i = 8'h3C;
        #1;
        chk("t1_ack", ctrl_ack_o, 4'b0010);
        chk("t1_rdat", ctrl_dat_o, 8'h3C);
        tick();
        dev_ack_i = 1'b0; req(1, 1'b0); ctrl_we_i[1] = 1'b0;
        #1;
        chk("t1_ack_one_cycle", ctrl_ack_o, 0);
        chk("t1_release_dev_cyc", dev_cyc_o, 0);
        tick();
        chk("t1_idle_after", grant_o, 0);

        // ---------------- 2: all four from reset ----------------
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        for (int k = 0; k < N; k++) req(k, 1'b1);
        #1;
        chk("t2_idle_grant", grant_o, 0);
        for (int k = 0; k < N; k++) begin
            tick();
            chk($sformatf("t2_grant%0d", k), grant_o, 32'(1 << k));
            dev_ack_i = 1'b1;
            #1;
            chk($sformatf("t2_ack%0d", k), ctrl_ack_o, 32'(1 << k));
            tick();
            dev_ack_i = 1'b0; req(k, 1'b0);
            #1;
            chk($sformatf("t2_drop%0d", k), dev_cyc_o, 0);
            tick();
            chk($sformatf("t2_gap%0d", k), grant_o, 0);
        end

        // ---------------- 3: ctrl2 back-to-back, ctrl0 waits ----------------
        req(2, 1'b1);
        tick();
        chk("t3_grant", grant_o, 4'b0100);
        req(0, 1'b1);
        for (int t = 0; t < 3; t++) begin
            dev_ack_i = 1'b1;
            dev_rty_i = (t == 1);
            #1;
            chk($sformatf("t3_hold%0d", t), grant_o, 4'b0100);
            chk($sformatf("t3_ack%0d", t), ctrl_ack_o, 4'b0100);
            chk($sformatf("t3_rty%0d", t), ctrl_rty_o, (t == 1) ? 4'b0100 : 4'b0000);
            tick();
        end
        dev_ack_i = 1'b0; dev_rty_i = 1'b0; req(2, 1'b0);
        #1;
        chk("t3_drop_dev_cyc", dev_cyc_o, 0);
        tick();
        chk("t3_gap", grant_o, 0);
        tick();
        chk("t3_ctrl0_grant", grant_o, 4'b0001);
        req(0, 1'b0);
        tick();

        // ---------------- 4: watchdog abort on ctrl3 ----------------
        req(3, 1'b1);
        tick();
        chk("t4_grant", grant_o, 4'b1000);
        req(0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk($sformatf("t4_wait_err%0d", w), ctrl_err_o, 0);
            chk($sformatf("t4_wait_cyc%0d", w), dev_cyc_o, 1);
        end
        tick();
        chk("t4_abort_err", ctrl_err_o, 4'b1000);
        chk("t4_abort_dev_cyc", dev_cyc_o, 0);
        chk("t4_abort_ack", ctrl_ack_o, 0);
        tick();
        chk("t4_err_one_cycle", ctrl_err_o, 0);
        chk("t4_idle", grant_o, 0);
        tick();
        chk("t4_next_from_ctrl0", grant_o, 4'b0001);
        req(0, 1'b0); req(3, 1'b0);
        tick();

        // ---------------- 5: ack on the 4th wait cycle ----------------
        req(3, 1'b1);
        tick();
        chk("t5_grant", grant_o, 4'b1000);
        tick(); tick(); tick();
        dev_ack_i = 1'b1;
        #1;
        chk("t5_ack", ctrl_ack_o, 4'b1000);
        chk("t5_no_err", ctrl_err_o, 0);
        tick();
        dev_ack_i = 1'b0;
        #1;
        chk("t5_still_owned", grant_o, 4'b1000);
        chk("t5_no_abort_err", ctrl_err_o, 0);
        chk("t5_dev_cyc", dev_cyc_o, 1);
        req(3, 1'b0);
        tick();

        // ---------------- 6: reset mid-transfer ----------------
        req(1, 1'b1);
        tick();
        chk("t6_grant", grant_o, 4'b0010);
        chk("t6_dev_cyc", dev_cyc_o, 1);
        rst_ni = 1'b0; dev_ack_i = 1'b1;
        #1;
        chk("t6_rst_dev_cyc", dev_cyc_o, 0);
        chk("t6_rst_grant", grant_o, 0);
        chk("t6_rst_no_ack", ctrl_ack_o, 0);
        tick();
        dev_ack_i = 1'b0; rst_ni = 1'b1; req(0, 1'b1);
        tick();
        chk("t6_next_from_ctrl0", grant_o, 4'b0001);
        req(0, 1'b0); req(1, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
